// File: rtl/video_frame_monitor_pkg.sv
// Purpose: shared types and constants for the video frame monitor.
// Contents: FSM state enum, checksum width, oErr bit indices, lock threshold,
//           and the 1-bit rotate-left helper used by the checksum.
package video_frame_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_V  = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    localparam int unsigned CHK_W       = 16;
    localparam int unsigned ERR_W       = 3;
    localparam int unsigned ERR_LINE    = 0;
    localparam int unsigned ERR_COUNT   = 1;
    localparam int unsigned ERR_OVF     = 2;
    localparam int unsigned LOCK_THRESH = 2;
    localparam int unsigned GOOD_W      = 2;

    function automatic logic [CHK_W-1:0] rotl1(input logic [CHK_W-1:0] v);
        return {v[CHK_W-2:0], v[CHK_W-1]};
    endfunction

endpackage

// File: rtl/video_frame_monitor_if.sv
// Purpose: video stream bundle observed by the frame monitor.
// Signals: iColor (pixel, channel 0 in LSBs), iVde (data enable), iVSync (raw vsync).
// Modports: master = video source, slave = monitor.
interface video_frame_monitor_if
    import video_frame_monitor_pkg::*;
#(
    parameter int unsigned pColorWidth = 12
) ();

    logic [pColorWidth-1:0] iColor;
    logic                   iVde;
    logic                   iVSync;

    modport master (output iColor, iVde, iVSync);
    modport slave  (input  iColor, iVde, iVSync);

endinterface

// File: rtl/vfm_checksum.sv
// Purpose: per-frame pixel checksum, sum <= rotl1(sum) ^ fold(pixel) per enabled pixel.
// Ports: clk, rst (sync, active-high), clear (restart at 0 after this cycle),
//        enable (pixel valid), pixel, sum_c (sum including this cycle's pixel).
// Only instantiated when VIDEO_FRAME_MONITOR_CHECKSUM_EN is defined.
module vfm_checksum
    import video_frame_monitor_pkg::*;
#(
    parameter int unsigned pPixW = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [pPixW-1:0] pixel,
    output logic [CHK_W-1:0] sum_c
);

    localparam int unsigned NSLICE = (pPixW + CHK_W - 1) / CHK_W;
    localparam int unsigned PADW   = NSLICE * CHK_W;

    logic [CHK_W-1:0] sum_q;
    logic [CHK_W-1:0] sum_d;
    logic [CHK_W-1:0] fold_c;
    logic [PADW-1:0]  pad_c;

    // Fold the zero-extended pixel into 16 bits; sum_c already includes it so a
    // frame end on a pixel cycle captures that pixel before the clear.
    always_comb begin
        pad_c  = PADW'(pixel);
        fold_c = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            fold_c = fold_c ^ pad_c[i*CHK_W +: CHK_W];
        end
        sum_c = enable ? (rotl1(sum_q) ^ fold_c) : sum_q;
        sum_d = clear ? '0 : sum_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/video_frame_monitor.sv
// Purpose: measures active line length, line count and checksum of each video
//          frame between normalised vsync rising edges, flags timing errors and
//          reports a lock once timing is stable.
// Ports: iClk, iRst (sync, active-high), iEn, iSyncNeg, iHdisplay, iVdisplay,
//        vid (slave: iColor, iVde, iVSync), oFe, oHCnt, oVCnt, oErr, oChecksum,
//        oFrameCnt, oLocked.
// Build option: VIDEO_FRAME_MONITOR_CHECKSUM_EN adds the checksum; otherwise oChecksum=0.
module video_frame_monitor
    import video_frame_monitor_pkg::*;
#(
    parameter int unsigned pColorBit      = 4,
    parameter int unsigned pChannels      = 3,
    parameter int unsigned pHdisplayWidth = 11,
    parameter int unsigned pVdisplayWidth = 11,
    parameter int unsigned pFrameCntWidth = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iEn,
    input  logic                      iSyncNeg,
    input  logic [pHdisplayWidth:0]   iHdisplay,
    input  logic [pVdisplayWidth:0]   iVdisplay,
    video_frame_monitor_if.slave      vid,
    output logic                      oFe,
    output logic [pHdisplayWidth:0]   oHCnt,
    output logic [pVdisplayWidth:0]   oVCnt,
    output logic [ERR_W-1:0]          oErr,
    output logic [CHK_W-1:0]          oChecksum,
    output logic [pFrameCntWidth-1:0] oFrameCnt,
    output logic                      oLocked
);

    localparam int unsigned HW   = pHdisplayWidth + 1;
    localparam int unsigned VW   = pVdisplayWidth + 1;
    localparam int unsigned PIXW = pChannels * pColorBit;
    localparam int unsigned FCW  = pFrameCntWidth;

    state_e            state_q, state_d;
    logic              vs_q, vs_d, vde_q, vde_d;
    logic [HW-1:0]     pix_q, pix_d, len_q, len_d, hcnt_q, hcnt_d;
    logic [VW-1:0]     line_q, line_d, vcnt_q, vcnt_d;
    logic              lerr_q, lerr_d, ovf_q, ovf_d;
    logic              fe_q, fe_d, lock_q, lock_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic              vs_n_c, vs_edge_c, line_end_c, frame_end_c;
    logic [HW-1:0]     pix_n, len_n;
    logic [VW-1:0]     line_n;
    logic              lerr_n, ovf_n;
    logic [ERR_W-1:0]  err_n;
    logic [GOOD_W-1:0] good_n;

    assign vs_n_c      = vid.iVSync ^ iSyncNeg;
    assign vs_edge_c   = vs_n_c & ~vs_q;
    // vde_q is only set inside a frame, so a line end never straddles a frame boundary.
    assign line_end_c  = vde_q & ~vid.iVde;
    assign frame_end_c = (state_q == ST_MEASURE) & iEn & vs_edge_c;
    assign vs_d        = vs_n_c;
    assign vde_d       = vid.iVde & (state_q == ST_MEASURE) & iEn & ~vs_edge_c;

    // Next-state, per-frame accumulation and frame-end result capture.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        line_d  = line_q;
        len_d   = len_q;
        lerr_d  = lerr_q;
        ovf_d   = ovf_q;
        fe_d    = 1'b0;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;
        good_d  = good_q;
        lock_d  = lock_q;
        pix_n   = pix_q;
        line_n  = line_q;
        len_n   = len_q;
        lerr_n  = lerr_q;
        ovf_n   = ovf_q;
        err_n   = '0;
        good_n  = good_q;

        case (state_q)
            ST_IDLE: begin
                good_d = '0;
                lock_d = 1'b0;
                if (iEn) state_d = ST_WAIT_V;
            end
            ST_WAIT_V: begin
                if (vs_edge_c) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (iEn) begin
                    if (vid.iVde) begin
                        if (&pix_q) ovf_n = 1'b1;
                        else        pix_n = pix_q + HW'(1);
                    end
                    // A completed line, or a partial line cut off by vsync (always an error).
                    if (line_end_c || (vs_edge_c && vid.iVde)) begin
                        if (!line_end_c || (pix_n != iHdisplay)) lerr_n = 1'b1;
                        if (&line_q) ovf_n  = 1'b1;
                        else         line_n = line_q + VW'(1);
                        len_n = pix_n;
                        pix_n = '0;
                    end
                    pix_d  = pix_n;
                    line_d = line_n;
                    len_d  = len_n;
                    lerr_d = lerr_n;
                    ovf_d  = ovf_n;
                    if (vs_edge_c) begin
                        err_n[ERR_LINE]  = lerr_n;
                        err_n[ERR_COUNT] = (line_n != iVdisplay);
                        err_n[ERR_OVF]   = ovf_n;
                        fe_d   = 1'b1;
                        hcnt_d = len_n;
                        vcnt_d = line_n;
                        err_d  = err_n;
                        fcnt_d = fcnt_q + FCW'(1);
                        if (err_n == '0) begin
                            good_n = (good_q == GOOD_W'(LOCK_THRESH)) ? good_q : good_q + GOOD_W'(1);
                            good_d = good_n;
                            lock_d = (good_n == GOOD_W'(LOCK_THRESH));
                        end else begin
                            good_d = '0;
                            lock_d = 1'b0;
                        end
                        pix_d  = '0;
                        line_d = '0;
                        len_d  = '0;
                        lerr_d = 1'b0;
                        ovf_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accumulators only live inside MEASURE.
        if (state_q != ST_MEASURE) begin
            pix_d  = '0;
            line_d = '0;
            len_d  = '0;
            lerr_d = 1'b0;
            ovf_d  = 1'b0;
        end

        if (!iEn) begin
            state_d = ST_IDLE;
            good_d  = '0;
            lock_d  = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            vs_q    <= 1'b0;
            vde_q   <= 1'b0;
            pix_q   <= '0;
            line_q  <= '0;
            len_q   <= '0;
            lerr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            fe_q    <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            err_q   <= '0;
            fcnt_q  <= '0;
            good_q  <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_d;
            vde_q   <= vde_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            len_q   <= len_d;
            lerr_q  <= lerr_d;
            ovf_q   <= ovf_d;
            fe_q    <= fe_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
            good_q  <= good_d;
            lock_q  <= lock_d;
        end
    end

`ifdef VIDEO_FRAME_MONITOR_CHECKSUM_EN
    logic             chk_en_c, chk_clr_c;
    logic [CHK_W-1:0] sum_c, chk_q, chk_d;

    assign chk_en_c  = (state_q == ST_MEASURE) & iEn & vid.iVde;
    assign chk_clr_c = ~((state_q == ST_MEASURE) & iEn) | vs_edge_c;

    vfm_checksum #(.pPixW(PIXW)) u_checksum (
        .clk    (iClk),
        .rst    (iRst),
        .clear  (chk_clr_c),
        .enable (chk_en_c),
        .pixel  (vid.iColor),
        .sum_c  (sum_c)
    );

    // Frame checksum result register.
    always_comb begin
        chk_d = chk_q;
        if (frame_end_c) chk_d = sum_c;
    end

    always_ff @(posedge iClk) begin
        if (iRst) chk_q <= '0;
        else      chk_q <= chk_d;
    end

    assign oChecksum = chk_q;
`else
    logic unused_color_c;
    assign unused_color_c = ^{vid.iColor, frame_end_c, PIXW'(0)};
    assign oChecksum      = '0;
`endif

    assign oFe       = fe_q;
    assign oHCnt     = hcnt_q;
    assign oVCnt     = vcnt_q;
    assign oErr      = err_q;
    assign oFrameCnt = fcnt_q;
    assign oLocked   = lock_q;

endmodule

// File: tb/tb_video_frame_monitor.sv
// Purpose: directed self-checking bench for video_frame_monitor: reset state,
//          32x32 frame measurement and lock, short line, vde across vsync,
//          checksum and empty frames, sync polarity, mid-frame disable/reset.
module tb_video_frame_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sneg;
    logic [11:0] hd;
    logic [11:0] vd;
    logic        oFe;
    logic [11:0] oHCnt;
    logic [11:0] oVCnt;
    logic [2:0]  oErr;
    logic [15:0] oChecksum;
    logic [15:0] oFrameCnt;
    logic        oLocked;

    int checks   = 0;
    int failures = 0;
    int fe_count = 0;

`ifdef VIDEO_FRAME_MONITOR_CHECKSUM_EN
    localparam logic [15:0] EXP_CHK = 16'h0550;
`else
    localparam logic [15:0] EXP_CHK = 16'h0000;
`endif

    video_frame_monitor_if #(.pColorWidth(12)) vid ();

    video_frame_monitor dut (
        .iClk      (clk),
        .iRst      (rst),
        .iEn       (en),
        .iSyncNeg  (sneg),
        .iHdisplay (hd),
        .iVdisplay (vd),
        .vid       (vid),
        .oFe       (oFe),
        .oHCnt     (oHCnt),
        .oVCnt     (oVCnt),
        .oErr      (oErr),
        .oChecksum (oChecksum),
        .oFrameCnt (oFrameCnt),
        .oLocked   (oLocked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (oFe) fe_count++;

    // One clock: drive inputs, let the edge sample them, look #1 after.
    task automatic cyc(input logic vde, input logic vs, input logic [11:0] col);
        vid.iVde   = vde;
        vid.iVSync = vs ^ sneg;
        vid.iColor = col;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 12'h000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    // Rest of a 113x58 frame after its first (vsync edge) cycle.
    // Lines 0-9 sync, 10-13 back porch, 14-45 active, 46-57 front porch.
    task automatic frame_rest(input int short_line);
        int na;
        for (int l = 0; l < 58; l++) begin
            for (int c = 0; c < 113; c++) begin
                if (!(l == 0 && c == 0)) begin
                    na = (l >= 14 && l < 46) ? (((l - 14) == short_line) ? 31 : 32) : 0;
                    cyc(c < na, l < 10, 12'h000);
                end
            end
        end
    endtask

    task automatic small_line(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 12'h0f0);
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        idle(3);
        checks++; if (oFe !== 1'b0) begin failures++; $display("FAIL reset_fe got=%0d exp=0", oFe); end
        checks++; if (oHCnt !== 12'd0) begin failures++; $display("FAIL reset_hcnt got=%0d exp=0", oHCnt); end
        checks++; if (oVCnt !== 12'd0) begin failures++; $display("FAIL reset_vcnt got=%0d exp=0", oVCnt); end
        checks++; if (oErr !== 3'b000) begin failures++; $display("FAIL reset_err got=%b exp=000", oErr); end
        checks++; if (oChecksum !== 16'h0000) begin failures++; $display("FAIL reset_chk got=%h exp=0000", oChecksum); end
        checks++; if (oFrameCnt !== 16'd0) begin failures++; $display("FAIL reset_fcnt got=%0d exp=0", oFrameCnt); end
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL reset_lock got=%0d exp=0", oLocked); end
        rst = 1'b0;
    endtask

    task automatic test_basic_lock(input string tag);
        hd = 12'd32; vd = 12'd32; en = 1'b1;
        idle(3);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oFe !== 1'b0) begin failures++; $display("FAIL %s_first_edge_fe got=%0d exp=0", tag, oFe); end
        frame_rest(-1);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oFe !== 1'b1) begin failures++; $display("FAIL %s_fe1 got=%0d exp=1", tag, oFe); end
        checks++; if (oHCnt !== 12'd32) begin failures++; $display("FAIL %s_hcnt got=%0d exp=32", tag, oHCnt); end
        checks++; if (oVCnt !== 12'd32) begin failures++; $display("FAIL %s_vcnt got=%0d exp=32", tag, oVCnt); end
        checks++; if (oErr !== 3'b000) begin failures++; $display("FAIL %s_err got=%b exp=000", tag, oErr); end
        checks++; if (oFrameCnt !== 16'd1) begin failures++; $display("FAIL %s_fcnt1 got=%0d exp=1", tag, oFrameCnt); end
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL %s_lock1 got=%0d exp=0", tag, oLocked); end
        frame_rest(-1);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oFe !== 1'b1) begin failures++; $display("FAIL %s_fe2 got=%0d exp=1", tag, oFe); end
        checks++; if (oFrameCnt !== 16'd2) begin failures++; $display("FAIL %s_fcnt2 got=%0d exp=2", tag, oFrameCnt); end
        checks++; if (oLocked !== 1'b1) begin failures++; $display("FAIL %s_lock2 got=%0d exp=1", tag, oLocked); end
    endtask

    task automatic test_short_line();
        frame_rest(5);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oErr !== 3'b001) begin failures++; $display("FAIL short_err got=%b exp=001", oErr); end
        checks++; if (oHCnt !== 12'd32) begin failures++; $display("FAIL short_hcnt got=%0d exp=32", oHCnt); end
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL short_lock got=%0d exp=0", oLocked); end
        frame_rest(-1);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oErr !== 3'b000) begin failures++; $display("FAIL short_good1_err got=%b exp=000", oErr); end
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL short_good1_lock got=%0d exp=0", oLocked); end
        frame_rest(-1);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oLocked !== 1'b1) begin failures++; $display("FAIL short_relock got=%0d exp=1", oLocked); end
        checks++; if (oFrameCnt !== 16'd5) begin failures++; $display("FAIL short_fcnt got=%0d exp=5", oFrameCnt); end
    endtask

    task automatic test_vde_across_vsync();
        do_reset();
        hd = 12'd4; vd = 12'd3; en = 1'b1;
        idle(2);
        cyc(1'b0, 1'b1, 12'h000);
        small_line(4);
        small_line(4);
        cyc(1'b1, 1'b0, 12'h0f0);
        cyc(1'b1, 1'b0, 12'h0f0);
        checks++; if (oFe !== 1'b0) begin failures++; $display("FAIL vde_pre_fe got=%0d exp=0", oFe); end
        cyc(1'b1, 1'b1, 12'h0f0);
        checks++; if (oFe !== 1'b1) begin failures++; $display("FAIL vde_fe_latency got=%0d exp=1", oFe); end
        checks++; if (oErr !== 3'b001) begin failures++; $display("FAIL vde_err got=%b exp=001", oErr); end
        checks++; if (oHCnt !== 12'd3) begin failures++; $display("FAIL vde_hcnt got=%0d exp=3", oHCnt); end
        checks++; if (oVCnt !== 12'd3) begin failures++; $display("FAIL vde_vcnt got=%0d exp=3", oVCnt); end
        cyc(1'b0, 1'b0, 12'h000);
        checks++; if (oFe !== 1'b0) begin failures++; $display("FAIL vde_fe_pulse got=%0d exp=0", oFe); end
    endtask

    task automatic test_checksum_empty();
        do_reset();
        hd = 12'd4; vd = 12'd1; en = 1'b1;
        idle(2);
        cyc(1'b0, 1'b1, 12'h000);
        small_line(4);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oChecksum !== EXP_CHK) begin failures++; $display("FAIL chk_value got=%h exp=%h", oChecksum, EXP_CHK); end
        checks++; if (oErr !== 3'b000) begin failures++; $display("FAIL chk_err got=%b exp=000", oErr); end
        checks++; if (oHCnt !== 12'd4) begin failures++; $display("FAIL chk_hcnt got=%0d exp=4", oHCnt); end
        checks++; if (oVCnt !== 12'd1) begin failures++; $display("FAIL chk_vcnt got=%0d exp=1", oVCnt); end
        idle(3);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oVCnt !== 12'd0) begin failures++; $display("FAIL empty_vcnt got=%0d exp=0", oVCnt); end
        checks++; if (oErr !== 3'b010) begin failures++; $display("FAIL empty_err got=%b exp=010", oErr); end
        checks++; if (oChecksum !== 16'h0000) begin failures++; $display("FAIL empty_chk got=%h exp=0000", oChecksum); end
        vd = 12'd0;
        idle(3);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oErr !== 3'b000) begin failures++; $display("FAIL empty_vd0_err got=%b exp=000", oErr); end
        idle(3);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oLocked !== 1'b1) begin failures++; $display("FAIL empty_lock got=%0d exp=1", oLocked); end
        checks++; if (oFrameCnt !== 16'd4) begin failures++; $display("FAIL empty_fcnt got=%0d exp=4", oFrameCnt); end
    endtask

    task automatic test_mid_frame_disable();
        int fe0;
        cyc(1'b1, 1'b0, 12'h0f0);
        cyc(1'b1, 1'b0, 12'h0f0);
        en = 1'b0;
        cyc(1'b1, 1'b0, 12'h0f0);
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL dis_lock got=%0d exp=0", oLocked); end
        en = 1'b1;
        fe0 = fe_count;
        idle(1);
        checks++; if (oFrameCnt !== 16'd4) begin failures++; $display("FAIL dis_hold_fcnt got=%0d exp=4", oFrameCnt); end
        small_line(4);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oFe !== 1'b0) begin failures++; $display("FAIL dis_first_edge_fe got=%0d exp=0", oFe); end
        vd = 12'd1;
        small_line(4);
        checks++; if (fe_count - fe0 !== 0) begin failures++; $display("FAIL dis_no_fe got=%0d exp=0", fe_count - fe0); end
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oFe !== 1'b1) begin failures++; $display("FAIL dis_second_edge_fe got=%0d exp=1", oFe); end
        checks++; if (oFrameCnt !== 16'd5) begin failures++; $display("FAIL dis_fcnt got=%0d exp=5", oFrameCnt); end
    endtask

    task automatic test_mid_frame_reset();
        cyc(1'b1, 1'b0, 12'h0f0);
        cyc(1'b1, 1'b0, 12'h0f0);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 12'h0f0);
        rst = 1'b0;
        checks++; if (oFrameCnt !== 16'd0) begin failures++; $display("FAIL rst_mid_fcnt got=%0d exp=0", oFrameCnt); end
        checks++; if (oHCnt !== 12'd0) begin failures++; $display("FAIL rst_mid_hcnt got=%0d exp=0", oHCnt); end
        idle(1);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oFe !== 1'b0) begin failures++; $display("FAIL rst_mid_first_fe got=%0d exp=0", oFe); end
        small_line(4);
        cyc(1'b0, 1'b1, 12'h000);
        checks++; if (oFe !== 1'b1) begin failures++; $display("FAIL rst_mid_second_fe got=%0d exp=1", oFe); end
        checks++; if (oFrameCnt !== 16'd1) begin failures++; $display("FAIL rst_mid_fcnt1 got=%0d exp=1", oFrameCnt); end
        checks++; if (oVCnt !== 12'd1) begin failures++; $display("FAIL rst_mid_vcnt got=%0d exp=1", oVCnt); end
    endtask

    task automatic test_sync_neg();
        sneg = 1'b1;
        vid.iVSync = 1'b1;
        do_reset();
        test_basic_lock("neg");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sneg = 1'b0; hd = 12'd32; vd = 12'd32;
        vid.iVde = 1'b0; vid.iVSync = 1'b0; vid.iColor = 12'h000;
        test_reset();
        test_basic_lock("pos");
        test_short_line();
        test_vde_across_vsync();
        test_checksum_empty();
        test_mid_frame_disable();
        test_mid_frame_reset();
        test_sync_neg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_frame_monitor.md
VIDEO_FRAME_MONITOR -- requirements
Module: video_frame_monitor

Interface
REQ-001 pColorBit, 4, bits per colour channel.
REQ-002 pChannels, 3, colour channels per pixel.
REQ-003 pHdisplayWidth, 11, pixel-counter and iHdisplay width.
REQ-004 pVdisplayWidth, 11, line-counter and iVdisplay width.
REQ-005 pFrameCntWidth, 16, frame-counter width.
REQ-006 iClk  in  1  video clock; single clock domain.
REQ-007 iRst  in  1  reset; synchronous, active-high.
REQ-008 iEn  in  1  monitor enable.
REQ-009 iColor  in  pChannels*pColorBit  pixel data, channel 0 in the LSBs.
REQ-010 iVde  in  1  data enable.
REQ-011 iVSync  in  1  vertical sync, polarity selected by iSyncNeg.
REQ-012 iSyncNeg  in  1  1 = iVSync active-low.
REQ-013 iHdisplay / iVdisplay  in  pHdisplayWidth+1 / pVdisplayWidth+1  expected active pixels per line / lines per frame.
REQ-014 oFe  out  1  one-cycle frame-end pulse.
REQ-015 oHCnt / oVCnt  out  pHdisplayWidth+1 / pVdisplayWidth+1  measured last-line length / line count.
REQ-016 oErr  out  3  [0] line-length error, [1] line-count error, [2] counter overflow.
REQ-017 oChecksum  out  16  frame pixel checksum.
REQ-018 oFrameCnt  out  pFrameCntWidth  completed frames, wraps.
REQ-019 oLocked  out  1  stable-timing indicator.

Function
REQ-020 VSync is normalised as iVSync^iSyncNeg; its rising edge is detected against a registered copy (vsEdge).
REQ-021 States: IDLE, WAIT_V, MEASURE.
REQ-022 IDLE->WAIT_V when iEn=1; WAIT_V->MEASURE on vsEdge; any state->IDLE on the cycle after iEn=0.
REQ-023 In MEASURE, the pixel counter increments on each cycle with iVde=1 and saturates at all-ones, setting sticky overflow.
REQ-024 A line ends on the iVde 1->0 transition: compare the length with iHdisplay, set the sticky line error on mismatch, increment the line counter (saturating, sets overflow), latch the length, and clear the pixel counter.
REQ-025 vsEdge in MEASURE ends the frame.
REQ-026 If a line end coincides with vsEdge, the line is counted first.
REQ-027 If iVde=1 at vsEdge, the partial line is counted and flagged as a line error.
REQ-028 On the cycle after a frame end: oFe=1; oHCnt, oVCnt, oErr and oChecksum update (oErr[1] = line count != iVdisplay); oFrameCnt increments; all per-frame accumulators clear.
REQ-029 The frame-end latency from the vsEdge sample to oFe is exactly 1 cycle.
REQ-030 A frame with no active lines reports oVCnt=0 and sets oErr[1] unless iVdisplay=0.
REQ-031 The checksum applies per active pixel: chk <= rotl1(chk) ^ fold(iColor); fold = XOR of the 16-bit slices of the zero-extended pixel. It is initialised to 16'h0000 at frame start.
REQ-032 oLocked is set after 2 consecutive frames with oErr=0 and cleared by any frame with oErr!=0, by IDLE, or by reset.
REQ-033 Outputs hold their last frame result in IDLE and WAIT_V; oFe stays 0 there.
REQ-034 The WAIT_V->MEASURE edge does not produce oFe (partial first frame discarded).

Reset
REQ-035 iRst=1: state IDLE, all outputs and counters 0, vsEdge register 0, regardless of iEn.
REQ-036 Reset mid-frame discards the frame; the first oFe follows two vsEdges after iEn=1 is sampled post-reset.

Configuration
REQ-037 VIDEO_FRAME_MONITOR_CHECKSUM_EN defined: checksum logic per REQ-031.
REQ-038 VIDEO_FRAME_MONITOR_CHECKSUM_EN undefined: no checksum logic; oChecksum is constant 0; all other behaviour is unchanged.

Structure
REQ-039 video_frame_monitor_pkg holds the state enum, the checksum width constant (16), the oErr bit indices, and the lock threshold (2).
REQ-040 The checksum is a separate sub-module, vfm_checksum (clear, enable, pixel in, 16-bit sum out), instantiated only under the macro.

Verification
REQ-041 32x32 timing (H 32+8+30+43, V 32+12+10+4), iHdisplay=32, iVdisplay=32 -> oHCnt=32, oVCnt=32, oErr=0; oLocked=1 after the 2nd oFe.
REQ-042 One line with 31 pixels in frame 3 -> that frame oErr=3'b001, oLocked drops to 0, and relocks after 2 good frames.
REQ-043 iVde high across vsEdge -> oErr[0]=1, and oFe exactly 1 cycle after the vsEdge sample.
REQ-044 All pixels 12'h0f0 for 4 cycles from a fresh frame -> oChecksum=16'h0f0^rotl(...) matching a reference model; macro off -> 0.
REQ-045 iSyncNeg=1 with active-low VSync -> same results as REQ-041.
REQ-046 iEn or iRst asserted mid-frame -> IDLE, no oFe, oLocked=0, and the first oFe after the second subsequent vsEdge.
